fb_line_scheduler: RTL and testbench

- Schedules the single port of the 640x360x12-bit frame memory between display scanout and a host pixel writer.
- Display never reads frame memory directly. Each source row is prefetched into a ping/pong line buffer, then replayed for two output lines and 2x horizontally, giving 1280x720 output.
- Host writes use the remaining memory cycles.
- Sits between the timing generator, the frame memory, and the VGA output pins.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_line_buf.sv | 33 +++
 rtl/fb_line_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_fb_line_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants, FSM state encoding and pixel type for the frame-buffer line scheduler.
package fb_pkg;

    localparam int unsigned SRC_W   = 640;
    localparam int unsigned SRC_H   = 360;
    localparam int unsigned V_TOTAL = 750;
    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned COL_W   = 10;
    localparam int unsigned ROW_W   = 9;
    localparam int unsigned LINE_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/fb_line_buf.sv
// Ping/pong line buffer: two banks of DEPTH pixels, one write port, registered read port.
module fb_line_buf
    import fb_pkg::*;
#(
    parameter int unsigned DEPTH = SRC_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic             wbank,
    input  logic [COL_W-1:0] waddr,
    input  pixel_t           wdata,
    input  logic             rbank,
    input  logic [COL_W-1:0] raddr,
    output pixel_t           rdata
);

    localparam int unsigned IDX_W = $clog2(2 * DEPTH);

    pixel_t           mem [2*DEPTH];
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] ridx;

    assign widx = IDX_W'(32'(wbank) * DEPTH + 32'(waddr));
    assign ridx = IDX_W'(32'(rbank) * DEPTH + 32'(raddr));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        rdata <= mem[ridx];
    end

endmodule

// File: rtl/fb_line_scheduler.sv
// Arbitrates the single frame-memory port between row prefetch into the line buffer
// and host pixel writes, and replays the buffered row 2x2 onto the VGA pins.
module fb_line_scheduler
    import fb_pkg::*;
(
    input  logic              VGA_CLK,
    input  logic              reset,
    input  logic [LINE_W-1:0] line_value,
    input  logic [LINE_W-1:0] pixel_location,
    input  logic              visible_region,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [COL_W-1:0]  wr_x,
    input  logic [ROW_W-1:0]  wr_y,
    input  pixel_t            wr_data,
    output logic              wr_drop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output pixel_t            mem_wdata,
    input  pixel_t            mem_rdata,
    output logic              fill_overrun
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    state_t                          state;
    logic [ROW_W-1:0]                row;
    logic [COL_W-1:0]                col;
    logic [CNT_W-1:0]                drain_cnt;
    logic [LINE_W-1:0]               prev_line;
    logic                            new_line;
    logic                            trigger;
    logic [ROW_W-1:0]                trig_row;
    logic                            in_range;
    logic                            handshake;
    logic [MEM_LAT-1:0]              rd_valid;
    logic [MEM_LAT-1:0]              rd_bank;
    logic [MEM_LAT-1:0][COL_W-1:0]   rd_col;
    logic                            disp_in;
    logic [COL_W-1:0]                disp_col;
    logic                            vis_q;
    pixel_t                          buf_q;

    // Row prefetch trigger: last line of the frame preloads row 0, each even line preloads the next row.
    always_comb begin
        new_line = (line_value != prev_line);
        trigger  = 1'b0;
        trig_row = '0;
        if (new_line) begin
            if (32'(line_value) == V_TOTAL - 1) begin
                trigger = 1'b1;
            end else if (!line_value[0] && (32'(line_value) < 2 * SRC_H - 2)) begin
                trigger  = 1'b1;
                trig_row = ROW_W'((line_value >> 1) + 16'd1);
            end
        end
    end

    assign in_range  = (32'(wr_x) < SRC_W) && (32'(wr_y) < SRC_H);
    assign wr_ready  = (state == IDLE) && !trigger && !reset;
    assign handshake = wr_valid && wr_ready;

    // Memory port mux: fill reads own the port outside IDLE, host writes only in IDLE.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == FILL) begin
            mem_addr = ADDR_W'(32'(row) * SRC_W + 32'(col));
        end else if (handshake && in_range) begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'(32'(wr_y) * SRC_W + 32'(wr_x));
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            drain_cnt    <= '0;
            prev_line    <= 16'hFFFF;
            wr_drop      <= 1'b0;
            fill_overrun <= 1'b0;
        end else begin
            prev_line <= line_value;
            wr_drop   <= handshake && !in_range;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= FILL;
                        row   <= trig_row;
                        col   <= '0;
                    end
                end
                FILL: begin
                    if (trigger) begin
                        fill_overrun <= 1'b1;
                    end
                    if (col == COL_W'(SRC_W - 1)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                DRAIN: begin
                    if (trigger) begin
                        fill_overrun <= 1'b1;
                    end
                    if (drain_cnt == CNT_W'(MEM_LAT - 1)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tags travel alongside each outstanding read so returning data lands in the right slot.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            rd_valid <= '0;
            rd_bank  <= '0;
            rd_col   <= '0;
        end else begin
            rd_valid[0] <= (state == FILL);
            rd_bank[0]  <= row[0];
            rd_col[0]   <= col;
            for (int i = 1; i < MEM_LAT; i++) begin
                rd_valid[i] <= rd_valid[i-1];
                rd_bank[i]  <= rd_bank[i-1];
                rd_col[i]   <= rd_col[i-1];
            end
        end
    end

    assign disp_in  = (32'(pixel_location >> 1) < SRC_W);
    assign disp_col = disp_in ? pixel_location[COL_W:1] : '0;

    fb_line_buf #(
        .DEPTH (SRC_W)
    ) u_line_buf (
        .clk   (VGA_CLK),
        .we    (rd_valid[MEM_LAT-1]),
        .wbank (rd_bank[MEM_LAT-1]),
        .waddr (rd_col[MEM_LAT-1]),
        .wdata (mem_rdata),
        .rbank (line_value[1]),
        .raddr (disp_col),
        .rdata (buf_q)
    );

    // Second display stage: blank outside active video or past the buffered row width.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            vis_q <= 1'b0;
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else begin
            vis_q <= visible_region && disp_in;
            if (vis_q) begin
                VGA_R <= {buf_q[11:8], 4'h0};
                VGA_G <= {buf_q[7:4], 4'h0};
                VGA_B <= {buf_q[3:0], 4'h0};
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fb_line_scheduler.sv
// Directed bench for fb_line_scheduler with a behavioural frame memory and a display scoreboard.
module tb_fb_line_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] line_value;
    logic [15:0] pixel_location;
    logic        visible_region;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [11:0] wr_data;
    logic        wr_drop;
    logic [17:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        fill_overrun;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] fmem [0:262143];
    logic [11:0] rd_a1, rd_a2;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    fb_line_scheduler dut (
        .VGA_CLK        (clk),
        .reset          (reset),
        .line_value     (line_value),
        .pixel_location (pixel_location),
        .visible_region (visible_region),
        .VGA_R          (vga_r),
        .VGA_G          (vga_g),
        .VGA_B          (vga_b),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_x           (wr_x),
        .wr_y           (wr_y),
        .wr_data        (wr_data),
        .wr_drop        (wr_drop),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .fill_overrun   (fill_overrun)
    );

    // Frame memory model: word = address, 2-cycle read latency.
    initial begin
        for (int i = 0; i < 262144; i++) fmem[i] <= 12'(i);
    end

    always @(posedge clk) begin
        if (mem_we) fmem[mem_addr] <= mem_wdata;
        rd_a1 <= fmem[mem_addr];
        rd_a2 <= rd_a1;
    end
    assign mem_rdata = rd_a2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!wr_ready && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(wr_ready), 32'd1);
    endtask

    function automatic logic [31:0] exp_rgb(input logic [15:0] pix, input logic vis);
        logic [15:0] k;
        logic [11:0] w;
        k = pix >> 1;
        if (!vis || k >= 16'd640) return 32'd0;
        w = 12'(k);
        return {8'd0, w[11:8], 4'h0, w[7:4], 4'h0, w[3:0], 4'h0};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pix;
        logic        vis;
        int          n;

        reset = 1'b1; line_value = 16'd1; pixel_location = '0; visible_region = 1'b0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
        tick(); tick(); tick();
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_wr_drop", 32'(wr_drop), 0);
        chk("rst_overrun", 32'(fill_overrun), 0);
        chk("rst_vga", {8'd0, vga_r, vga_g, vga_b}, 0);
        tick(); reset = 1'b0; #1;
        chk("ready_after_rst", 32'(wr_ready), 1);
        tick(); tick();

        // Row 0 fill on the last frame line.
        tick(); line_value = 16'd749; #1;
        chk("fill_trig_ready", 32'(wr_ready), 0);
        for (int k = 0; k < 640; k++) exp_q.push_back(32'(k));
        for (int k = 0; k < 640; k++) begin
            tick();
            chk("fill_addr", 32'(mem_addr), exp_q.pop_front());
            chk("fill_we", 32'(mem_we), 0);
        end
        for (int d = 0; d < 2; d++) begin
            tick();
            chk("drain_busy", 32'(wr_ready), 0);
        end
        tick();
        chk("idle_after_drain", 32'(wr_ready), 1);

        // Display replay of bank 0 on line 0.
        tick(); line_value = 16'd0;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (i < 24) begin
                if (i < 12)      begin pix = 16'(i);             vis = 1'b1; end
                else if (i < 16) begin pix = 16'(i);             vis = 1'b0; end
                else             begin pix = 16'(1274 + i - 16); vis = 1'b1; end
                pixel_location = pix;
                visible_region = vis;
                exp_q.push_back(exp_rgb(pix, vis));
            end else begin
                visible_region = 1'b0;
            end
            #1;
            if (i >= 2) chk("display_rgb", {8'd0, vga_r, vga_g, vga_b}, exp_q.pop_front());
        end
        wait_ready("row1_fill_done", 1000);

        // In-range host write.
        tick(); wr_valid = 1'b1; wr_x = 10'd5; wr_y = 9'd3; wr_data = 12'hABC; #1;
        chk("wr_ready", 32'(wr_ready), 1);
        chk("wr_we", 32'(mem_we), 1);
        chk("wr_addr", 32'(mem_addr), 1925);
        chk("wr_wdata", 32'(mem_wdata), 32'hABC);
        tick(); wr_valid = 1'b0; #1;
        chk("wr_no_drop", 32'(wr_drop), 0);
        chk("wr_mem_content", 32'(fmem[1925]), 32'hABC);

        // Out-of-range host writes.
        tick(); wr_valid = 1'b1; wr_x = 10'd640; wr_y = 9'd0; #1;
        chk("oor_x_ready", 32'(wr_ready), 1);
        chk("oor_x_we", 32'(mem_we), 0);
        tick(); wr_valid = 1'b0; #1;
        chk("oor_x_drop", 32'(wr_drop), 1);
        tick();
        chk("oor_x_drop_end", 32'(wr_drop), 0);
        tick(); wr_valid = 1'b1; wr_x = 10'd0; wr_y = 9'd360; #1;
        chk("oor_y_we", 32'(mem_we), 0);
        tick(); wr_valid = 1'b0; #1;
        chk("oor_y_drop", 32'(wr_drop), 1);

        // Trigger beats a simultaneous host write.
        tick(); line_value = 16'd2; wr_valid = 1'b1; wr_x = 10'd7; wr_y = 9'd2; wr_data = 12'h123; #1;
        chk("conf_ready", 32'(wr_ready), 0);
        chk("conf_we", 32'(mem_we), 0);
        tick();
        chk("conf_fill_addr", 32'(mem_addr), 1280);
        chk("conf_fill_we", 32'(mem_we), 0);
        n = 0;
        while (!wr_ready && n < 1000) begin
            tick();
            n++;
        end
        chk("conf_wait", 32'(n), 642);
        chk("conf_wr_we", 32'(mem_we), 1);
        chk("conf_wr_addr", 32'(mem_addr), 1287);
        chk("conf_wr_wdata", 32'(mem_wdata), 32'h123);
        tick(); wr_valid = 1'b0;

        // Overrun during fill, then reset mid-fill.
        tick(); line_value = 16'd4; #1;
        chk("ovr_trig", 32'(wr_ready), 0);
        for (int k = 0; k < 5; k++) tick();
        chk("ovr_col4", 32'(mem_addr), 1924);
        line_value = 16'd6; #1;
        chk("ovr_not_yet", 32'(fill_overrun), 0);
        tick();
        chk("ovr_set", 32'(fill_overrun), 1);
        chk("ovr_no_restart", 32'(mem_addr), 1925);
        for (int k = 6; k <= 100; k++) tick();
        chk("ovr_col100", 32'(mem_addr), 2020);
        chk("ovr_sticky", 32'(fill_overrun), 1);
        reset = 1'b1; line_value = 16'd7; #1;
        chk("rst_hold_ready", 32'(wr_ready), 0);
        tick(); reset = 1'b0; #1;
        chk("rst_ovr_clear", 32'(fill_overrun), 0);
        for (int k = 0; k < 8; k++) begin
            chk("rst_no_reads", {13'd0, mem_addr, mem_we, wr_ready}, {13'd0, 18'd0, 1'b0, 1'b1});
            tick();
        end

        // Last-row boundary: 718 does not trigger, 716 fills row 359.
        tick(); line_value = 16'd718; #1;
        chk("line718_ready", 32'(wr_ready), 1);
        tick();
        chk("line718_idle", {31'd0, wr_ready}, 1);
        chk("line718_addr", 32'(mem_addr), 0);
        tick(); line_value = 16'd716; #1;
        chk("line716_ready", 32'(wr_ready), 0);
        tick();
        chk("line716_addr", 32'(mem_addr), 229760);
        wait_ready("line716_done", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
